// File: rtl/one_bit_alu_cell_if.sv
// Operand/control/result bundle for one ALU bit slice.
// The parent (or bench) drives operands as master; the slice answers as slave.
interface one_bit_alu_cell_if;
    logic       A;
    logic       B;
    logic       Bnot;
    logic       C;
    logic [2:0] cntrl;
    logic       result;
    logic       carry_out;

    modport master (output A, B, Bnot, C, cntrl, input result, carry_out);
    modport slave  (input A, B, Bnot, C, cntrl, output result, carry_out);
endinterface

// File: rtl/one_bit_alu_cell.sv
// Single-bit ALU slice: gate-level full adder plus 2:1 and 8:1 mux trees.
// Result and carry-out are registered, giving one cycle of latency.
module one_bit_alu_cell_mux2 (
    input  logic i_in0,
    input  logic i_in1,
    input  logic i_sel,
    output logic o_out
);
    assign o_out = (i_in0 & ~i_sel) | (i_in1 & i_sel);
endmodule

module one_bit_alu_cell_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_cout
);
    logic w_ab_x;
    assign w_ab_x = i_a ^ i_b;
    assign o_sum  = w_ab_x ^ i_c;
    assign o_cout = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// cntrl[0] steers the leaves, cntrl[2] the root.
module one_bit_alu_cell_mux8 (
    input  logic [7:0] i_in,
    input  logic [2:0] i_sel,
    output logic       o_out
);
    logic [3:0] w_l0;
    logic [1:0] w_l1;

    for (genvar g = 0; g < 4; g++) begin : g_leaf
        one_bit_alu_cell_mux2 u_m (
            .i_in0(i_in[2*g]), .i_in1(i_in[2*g+1]), .i_sel(i_sel[0]), .o_out(w_l0[g])
        );
    end
    for (genvar g = 0; g < 2; g++) begin : g_mid
        one_bit_alu_cell_mux2 u_m (
            .i_in0(w_l0[2*g]), .i_in1(w_l0[2*g+1]), .i_sel(i_sel[1]), .o_out(w_l1[g])
        );
    end
    one_bit_alu_cell_mux2 u_root (
        .i_in0(w_l1[0]), .i_in1(w_l1[1]), .i_sel(i_sel[2]), .o_out(o_out)
    );
endmodule

module one_bit_alu_cell #(
    parameter real GATE_DELAY = 0.5
) (
    input  logic                 clk,
    input  logic                 reset,
    one_bit_alu_cell_if.slave    bus
);
    logic       w_bin;
    logic       w_sum;
    logic       w_cout;
    logic       w_res_nxt;
    logic [7:0] w_sel_in;
    logic       r_result;
    logic       r_carry;

    one_bit_alu_cell_mux2 u_binv (
        .i_in0(bus.B), .i_in1(bus.Bnot), .i_sel(bus.cntrl[0]), .o_out(w_bin)
    );

    one_bit_alu_cell_fa u_fa (
        .i_a(bus.A), .i_b(w_bin), .i_c(bus.C), .o_sum(w_sum), .o_cout(w_cout)
    );

    // Logic ops deliberately use raw B; only the adder sees the inverted operand.
    assign w_sel_in = {1'b0, bus.A ^ bus.B, bus.A | bus.B, bus.A & bus.B,
                       w_sum, w_sum, 1'b0, bus.B};

    one_bit_alu_cell_mux8 u_opsel (
        .i_in(w_sel_in), .i_sel(bus.cntrl), .o_out(w_res_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            r_result <= w_res_nxt;
            r_carry  <= w_cout;
        end
    end

    assign bus.result    = r_result;
    assign bus.carry_out = r_carry;
endmodule

// File: tb/tb_one_bit_alu_cell.sv
// Directed bench for one_bit_alu_cell: hand-computed vectors plus a 64-vector sweep.
`timescale 1ns/10ps
module tb_one_bit_alu_cell;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    one_bit_alu_cell_if bus ();

    one_bit_alu_cell #(.GATE_DELAY(0.5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic a, input logic b, input logic bn, input logic c,
                         input logic [2:0] op);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.Bnot = bn; bus.C = c; bus.cntrl = op;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0, 3'b000);
        reset = 1'b0;
        step();
        total++;
        if (bus.result !== 1'b1) begin
            bad++; $display("FAIL reset_pre result got=%b want=1", bus.result);
        end
        total++;
        if (bus.carry_out !== 1'b1) begin
            bad++; $display("FAIL reset_pre carry got=%b want=1", bus.carry_out);
        end
        @(negedge clk); reset = 1'b1;
        step();
        total++;
        if (bus.result !== 1'b0 || bus.carry_out !== 1'b0) begin
            bad++; $display("FAIL reset_clear got=%b%b want=00", bus.result, bus.carry_out);
        end
        @(negedge clk); reset = 1'b0;
        step();
        total++;
        if (bus.result !== 1'b1) begin
            bad++; $display("FAIL reset_recapture result got=%b want=1", bus.result);
        end
    endtask

    task automatic test_add();
        logic [4:0] vec [3];
        logic [1:0] exp [3];
        vec[0] = 5'b1_1_0_0_0; exp[0] = 2'b01;
        vec[1] = 5'b1_0_1_1_0; exp[1] = 2'b01;
        vec[2] = 5'b0_0_1_1_0; exp[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            drive(vec[i][4], vec[i][3], vec[i][2], vec[i][1], 3'b010);
            step();
            total++;
            if ({bus.result, bus.carry_out} !== exp[i]) begin
                bad++; $display("FAIL add[%0d] got=%b%b want=%b", i, bus.result, bus.carry_out, exp[i]);
            end
        end
    endtask

    task automatic test_sub();
        drive(1, 1, 0, 1, 3'b011);
        step();
        total++;
        if ({bus.result, bus.carry_out} !== 2'b01) begin
            bad++; $display("FAIL sub0 got=%b%b want=01", bus.result, bus.carry_out);
        end
        drive(0, 1, 0, 1, 3'b011);
        step();
        total++;
        if ({bus.result, bus.carry_out} !== 2'b10) begin
            bad++; $display("FAIL sub1 got=%b%b want=10", bus.result, bus.carry_out);
        end
    endtask

    task automatic test_logic();
        logic [2:0] ops [3];
        logic [1:0] exp [3];
        ops[0] = 3'b100; exp[0] = 2'b00;
        ops[1] = 3'b101; exp[1] = 2'b11;
        ops[2] = 3'b110; exp[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, ops[i]);
            step();
            total++;
            if ({bus.result, bus.carry_out} !== exp[i]) begin
                bad++; $display("FAIL logic op=%b got=%b%b want=%b", ops[i], bus.result, bus.carry_out, exp[i]);
            end
        end
    endtask

    task automatic test_pass_zero();
        drive(0, 1, 0, 0, 3'b000);
        step();
        total++;
        if (bus.result !== 1'b1) begin
            bad++; $display("FAIL pass_b got=%b want=1", bus.result);
        end
        drive(1, 1, 0, 1, 3'b001);
        step();
        total++;
        if (bus.result !== 1'b0) begin
            bad++; $display("FAIL zero_001 got=%b want=0", bus.result);
        end
        drive(1, 1, 0, 1, 3'b111);
        step();
        total++;
        if (bus.result !== 1'b0) begin
            bad++; $display("FAIL zero_111 got=%b want=0", bus.result);
        end
    endtask

    // Outputs must not follow inputs between clock edges.
    task automatic test_hold();
        drive(1, 1, 0, 0, 3'b000);
        step();
        bus.B = 1'b0; bus.Bnot = 1'b1; bus.C = 1'b1;
        #3;
        total++;
        if ({bus.result, bus.carry_out} !== 2'b11) begin
            bad++; $display("FAIL hold got=%b%b want=11", bus.result, bus.carry_out);
        end
    endtask

    task automatic test_back_to_back();
        logic a, b, c, bin, s, co, r;
        logic [2:0] op;
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 8; k++) begin
                a = v[2]; b = v[1]; c = v[0]; op = k[2:0];
                bin = op[0] ? ~b : b;
                s   = a ^ bin ^ c;
                co  = (a & bin) | (a & c) | (bin & c);
                case (op)
                    3'd0: r = b;
                    3'd2, 3'd3: r = s;
                    3'd4: r = a & b;
                    3'd5: r = a | b;
                    3'd6: r = a ^ b;
                    default: r = 1'b0;
                endcase
                drive(a, b, ~b, c, op);
                step();
                total++;
                if ({bus.result, bus.carry_out} !== {r, co}) begin
                    bad++;
                    $display("FAIL sweep abc=%0d op=%0d got=%b%b want=%b%b",
                             v, k, bus.result, bus.carry_out, r, co);
                end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        bus.A = 0; bus.B = 0; bus.Bnot = 1; bus.C = 0; bus.cntrl = 3'b000;
        step();
        total++;
        if (bus.result !== 1'b0 || bus.carry_out !== 1'b0) begin
            bad++; $display("FAIL init_reset got=%b%b want=00", bus.result, bus.carry_out);
        end
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_pass_zero();
        test_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
